// File: rtl/mm_tile_controller.sv
// Tile-parametrised matrix-multiply schedule generator: walks row-major batches of
// TILE x TILE output tiles, streams A/B read addresses, and writes back P one batch late.
module mm_tile_controller #(
  parameter int ADDR_WIDTH = 16,
  parameter int TILE       = 8,
  parameter int TILE_LOG2  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  stall_i,
  output logic                  busy_o,
  output logic                  valid_o,
  input  logic [ADDR_WIDTH-1:0] m_i,
  input  logic [ADDR_WIDTH-1:0] k_i,
  input  logic [ADDR_WIDTH-1:0] n_i,
  input  logic [ADDR_WIDTH-1:0] base_addra_i,
  input  logic [ADDR_WIDTH-1:0] base_addrb_i,
  input  logic [ADDR_WIDTH-1:0] base_addrp_i,
  output logic                  batch_begin_o,
  output logic                  batch_end_o,
  output logic                  ensys_o,
  output logic                  bubble_o,
  output logic                  ena_o,
  output logic [ADDR_WIDTH-1:0] addra_o,
  output logic                  enb_o,
  output logic [ADDR_WIDTH-1:0] addrb_o,
  output logic                  enp_o,
  output logic                  wep_o,
  output logic [ADDR_WIDTH-1:0] addrp_o,
  output logic [ADDR_WIDTH-1:0] row_batch_o,
  output logic [ADDR_WIDTH-1:0] col_batch_o
);

  localparam logic [ADDR_WIDTH-1:0] TILE_W = ADDR_WIDTH'(TILE);
  localparam logic [ADDR_WIDTH:0]   TILE_M1 = (ADDR_WIDTH+1)'(TILE - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_DONE} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cyc_q, col_q, row_q;
  logic [ADDR_WIDTH-1:0] k_q, l_q, r_q, c_q;
  logic [ADDR_WIDTH-1:0] a_row_q, b_col_q, base_b_q;
  logic [ADDR_WIDTH-1:0] p_cur_q, p_prev_q;
  logic                  first_q;

  // Tile-count rounding is done one bit wider so m or n near 2^ADDR_WIDTH cannot wrap.
  logic [ADDR_WIDTH:0]   m_ceil, n_ceil;
  logic [ADDR_WIDTH-1:0] r_d, c_d, l_d;
  logic                  zero_dim;

  assign m_ceil   = {1'b0, m_i} + TILE_M1;
  assign n_ceil   = {1'b0, n_i} + TILE_M1;
  assign r_d      = ADDR_WIDTH'(m_ceil >> TILE_LOG2);
  assign c_d      = ADDR_WIDTH'(n_ceil >> TILE_LOG2);
  assign l_d      = (k_i > TILE_W) ? k_i : TILE_W;
  assign zero_dim = (m_i == '0) || (k_i == '0) || (n_i == '0);

  logic last_cyc, last_col, last_row, last_drain;
  assign last_cyc   = (cyc_q == l_q - 1'b1);
  assign last_col   = (col_q == c_q - 1'b1);
  assign last_row   = (row_q == r_q - 1'b1);
  assign last_drain = (cyc_q == TILE_W - 1'b1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      k_q      <= '0;
      l_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      a_row_q  <= '0;
      b_col_q  <= '0;
      base_b_q <= '0;
      p_cur_q  <= '0;
      p_prev_q <= '0;
      first_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            k_q      <= k_i;
            l_q      <= l_d;
            r_q      <= r_d;
            c_q      <= c_d;
            a_row_q  <= base_addra_i;
            b_col_q  <= base_addrb_i;
            base_b_q <= base_addrb_i;
            p_cur_q  <= base_addrp_i;
            p_prev_q <= base_addrp_i;
            cyc_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            first_q  <= 1'b1;
            state_q  <= zero_dim ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          if (!stall_i) begin
            if (last_cyc) begin
              // The batch just finished becomes the one written back during the next batch.
              cyc_q    <= '0;
              p_prev_q <= p_cur_q;
              p_cur_q  <= p_cur_q + TILE_W;
              first_q  <= 1'b0;
              if (last_col && last_row) begin
                state_q <= S_DRAIN;
              end else if (last_col) begin
                col_q   <= '0;
                row_q   <= row_q + 1'b1;
                b_col_q <= base_b_q;
                a_row_q <= a_row_q + k_q;
              end else begin
                col_q   <= col_q + 1'b1;
                b_col_q <= b_col_q + k_q;
              end
            end else begin
              cyc_q <= cyc_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!stall_i) begin
            if (last_drain) begin
              cyc_q   <= '0;
              state_q <= S_DONE;
            end else begin
              cyc_q <= cyc_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!start_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic in_busy, in_drain, wr_win;
  assign in_busy  = (state_q == S_BUSY);
  assign in_drain = (state_q == S_DRAIN);
  assign wr_win   = (in_busy && !first_q && (cyc_q < TILE_W)) || in_drain;

  always_comb begin
    busy_o        = in_busy || in_drain;
    valid_o       = (state_q == S_DONE);
    batch_begin_o = (cyc_q == '0);
    batch_end_o   = in_busy && last_cyc;
    row_batch_o   = row_q;
    col_batch_o   = col_q;
    ensys_o       = 1'b0;
    bubble_o      = 1'b0;
    ena_o         = 1'b0;
    enb_o         = 1'b0;
    addra_o       = '0;
    addrb_o       = '0;
    enp_o         = 1'b0;
    wep_o         = 1'b0;
    addrp_o       = '0;
    if (in_busy) begin
      bubble_o = (cyc_q >= k_q);
      ensys_o  = !stall_i;
      ena_o    = !stall_i && !bubble_o;
      enb_o    = !stall_i && !bubble_o;
      addra_o  = a_row_q + cyc_q;
      addrb_o  = b_col_q + cyc_q;
    end
    if (in_drain) begin
      bubble_o = 1'b1;
      ensys_o  = !stall_i;
    end
    if (wr_win) begin
      addrp_o = p_prev_q + cyc_q;
      enp_o   = !stall_i;
      wep_o   = !stall_i;
    end
  end

endmodule

// File: tb/tb_mm_tile_controller.sv
// Directed bench for mm_tile_controller (TILE=8, ADDR_WIDTH=16).
module tb_mm_tile_controller;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stall;
  logic [AW-1:0] m, k, n, ba, bb, bp;
  logic          busy, valid, bbegin, bend, ensys, bubble, ena, enb, enp, wep;
  logic [AW-1:0] addra, addrb, addrp, rowb, colb;

  int errors = 0;
  int checks = 0;
  int lat, n_end;

  mm_tile_controller #(.ADDR_WIDTH(AW), .TILE(8), .TILE_LOG2(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stall_i(stall),
    .busy_o(busy), .valid_o(valid),
    .m_i(m), .k_i(k), .n_i(n),
    .base_addra_i(ba), .base_addrb_i(bb), .base_addrp_i(bp),
    .batch_begin_o(bbegin), .batch_end_o(bend), .ensys_o(ensys), .bubble_o(bubble),
    .ena_o(ena), .addra_o(addra), .enb_o(enb), .addrb_o(addrb),
    .enp_o(enp), .wep_o(wep), .addrp_o(addrp),
    .row_batch_o(rowb), .col_batch_o(colb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Each window starts 2ns after a rising edge; inputs change and outputs are read there.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_run(input logic [AW-1:0] mm, kk, nn, a0, b0, p0);
    tick();
    m = mm; k = kk; n = nn; ba = a0; bb = b0; bp = p0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    m = '0; k = '0; n = '0; ba = '0; bb = '0; bp = '0;
    #12;
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_valid",  32'(valid),  32'd0);
    chk("rst_begin",  32'(bbegin), 32'd1);
    chk("rst_ensys",  32'(ensys),  32'd0);
    chk("rst_ena",    32'(ena),    32'd0);
    chk("rst_enp",    32'(enp),    32'd0);
    chk("rst_addra",  32'(addra),  32'd0);
    chk("rst_row",    32'(rowb),   32'd0);
    tick();
    rst_n = 1'b1;

    // 8x8x8: one batch, then drain
    start_run(16'd8, 16'd8, 16'd8, 16'h000, 16'h100, 16'h200);
    for (int w = 0; w < 8; w++) begin
      chk("t1_addra",  32'(addra),  32'(w));
      chk("t1_addrb",  32'(addrb),  32'(16'h100 + w));
      chk("t1_bubble", 32'(bubble), 32'd0);
      chk("t1_ena",    32'(ena),    32'd1);
      chk("t1_enp",    32'(enp),    32'd0);
      chk("t1_bend",   32'(bend),   32'(w == 7));
      tick();
    end
    for (int w = 0; w < 8; w++) begin
      chk("t1_addrp", 32'(addrp), 32'(16'h200 + w));
      chk("t1_wep",   32'(wep),   32'd1);
      chk("t1_ena_d", 32'(ena),   32'd0);
      chk("t1_bub_d", 32'(bubble), 32'd1);
      chk("t1_vld_lo", 32'(valid), 32'd0);
      tick();
    end
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_busy",  32'(busy),  32'd0);

    // m=16 k=4 n=8: two batches of L=8 with bubbles on cyc 4..7
    start_run(16'd16, 16'd4, 16'd8, 16'h000, 16'h100, 16'h300);
    for (int w = 0; w < 8; w++) begin
      chk("t2_bubble0", 32'(bubble), 32'(w >= 4));
      chk("t2_ena0",    32'(ena),    32'(w < 4));
      chk("t2_enp0",    32'(enp),    32'd0);
      if (w < 4) chk("t2_addra0", 32'(addra), 32'(w));
      tick();
    end
    for (int w = 0; w < 8; w++) begin
      chk("t2_row1",   32'(rowb),  32'd1);
      chk("t2_enp1",   32'(enp),   32'd1);
      chk("t2_addrp1", 32'(addrp), 32'(16'h300 + w));
      if (w < 4) chk("t2_addra1", 32'(addra), 32'(4 + w));
      tick();
    end
    for (int w = 0; w < 8; w++) begin
      chk("t2_addrpd", 32'(addrp), 32'(16'h308 + w));
      tick();
    end
    chk("t2_valid", 32'(valid), 32'd1);

    // m=8 k=20 n=24: three columns of L=20
    start_run(16'd8, 16'd20, 16'd24, 16'h1000, 16'h2000, 16'h3000);
    lat = 1; n_end = 0;
    for (int w = 0; w < 200 && !valid; w++) begin
      if (bend) n_end++;
      if (w >= 40 && w < 60) begin
        chk("t3_addrb_c2", 32'(addrb), 32'(16'h2000 + 40 + (w - 40)));
        chk("t3_col2",     32'(colb),  32'd2);
      end
      tick();
      lat++;
    end
    chk("t3_bend_count", 32'(n_end), 32'd3);
    chk("t3_latency",    32'(lat),   32'd69);

    // 8x8x8 with 3 stalls mid-batch and 2 in drain
    start_run(16'd8, 16'd8, 16'd8, 16'h000, 16'h100, 16'h200);
    lat = 1;
    for (int w = 0; w < 200 && !valid; w++) begin
      stall = (w >= 3 && w <= 5) || (w == 13) || (w == 14);
      #1;
      if (stall) begin
        chk("t4_ensys_st", 32'(ensys), 32'd0);
        chk("t4_ena_st",   32'(ena),   32'd0);
        chk("t4_enp_st",   32'(enp),   32'd0);
      end
      if (w >= 3 && w <= 6)   chk("t4_addra_hold", 32'(addra), 32'd3);
      if (w >= 13 && w <= 15) chk("t4_addrp_hold", 32'(addrp), 32'h202);
      if (w == 6)  chk("t4_ena_resume", 32'(ena), 32'd1);
      if (w == 15) chk("t4_enp_resume", 32'(enp), 32'd1);
      tick();
      lat++;
    end
    stall = 1'b0;
    chk("t4_latency", 32'(lat), 32'd22);

    // k=0: straight to DONE, held while start stays high
    tick();
    tick();
    m = 16'd8; k = 16'd0; n = 16'd8;
    start = 1'b1;
    tick();
    chk("t5_valid",  32'(valid), 32'd1);
    chk("t5_busy",   32'(busy),  32'd0);
    chk("t5_ena",    32'(ena),   32'd0);
    chk("t5_enp",    32'(enp),   32'd0);
    tick();
    chk("t5_hold",   32'(valid), 32'd1);
    start = 1'b0;
    tick();
    chk("t5_idle_valid", 32'(valid), 32'd0);
    chk("t5_idle_busy",  32'(busy),  32'd0);

    // async reset at BUSY cyc 3, then a clean restart
    start_run(16'd8, 16'd8, 16'd8, 16'h000, 16'h100, 16'h200);
    tick(); tick(); tick();
    chk("t6_pre_addra", 32'(addra), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_busy",  32'(busy),   32'd0);
    chk("t6_ensys", 32'(ensys),  32'd0);
    chk("t6_ena",   32'(ena),    32'd0);
    chk("t6_enp",   32'(enp),    32'd0);
    chk("t6_begin", 32'(bbegin), 32'd1);
    chk("t6_addra", 32'(addra),  32'd0);
    tick();
    rst_n = 1'b1;
    start_run(16'd8, 16'd8, 16'd8, 16'h040, 16'h100, 16'h200);
    chk("t6_re_busy",  32'(busy),   32'd1);
    chk("t6_re_begin", 32'(bbegin), 32'd1);
    chk("t6_re_addra", 32'(addra),  32'h40);
    chk("t6_re_col",   32'(colb),   32'd0);
    chk("t6_re_row",   32'(rowb),   32'd0);
    lat = 1;
    for (int w = 0; w < 200 && !valid; w++) begin
      tick();
      lat++;
    end
    chk("t6_re_latency", 32'(lat), 32'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
